// File: rtl/vga_timing_640_480_if.sv
// vga_timing_640_480_if: pixel-address and sync bundle driven by the raster timing generator
interface vga_timing_640_480_if;
  logic [9:0] o_hidx;
  logic [8:0] o_vidx;
  logic       o_haddr_enb;
  logic       o_vaddr_enb;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_frame_en;
  modport master (output o_hidx, o_vidx, o_haddr_enb, o_vaddr_enb, o_hsync, o_vsync, o_frame_en);
  modport slave  (input  o_hidx, o_vidx, o_haddr_enb, o_vaddr_enb, o_hsync, o_vsync, o_frame_en);
endinterface

// File: rtl/vga_timing_640_480.sv
// vga_timing_640_480: chained horizontal/vertical raster FSMs producing registered pixel addresses and syncs
module vga_timing_640_480 #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                        clk,
  input  logic                        i_arst,
  input  logic                        i_sclr,
  input  logic                        i_px_clk,
  vga_timing_640_480_if.master        vga
);
  typedef enum logic [1:0] {ACT, FP, SYNC, BP} state_t;
  state_t      hstate, hstate_n, vstate, vstate_n;
  logic [10:0] hcnt, hcnt_n, vcnt, vcnt_n;
  logic [9:0]  hpix, hpix_n, hidx_n;
  logic [8:0]  vpix, vpix_n, vidx_n;
  logic        hlast, vlast, line_end, frame_last;
  logic        haddr_n, vaddr_n, hsync_n, vsync_n, frame_n;
  // State registers hold the next position; outputs are the decode of the position one tick behind.
  always_comb begin
    hlast      = hcnt == (hstate == ACT ? 11'(H_ACTIVE - 1) : hstate == FP ? 11'(H_FP - 1) :
                          hstate == SYNC ? 11'(H_SYNC - 1) : 11'(H_BP - 1));
    vlast      = vcnt == (vstate == ACT ? 11'(V_ACTIVE - 1) : vstate == FP ? 11'(V_FP - 1) :
                          vstate == SYNC ? 11'(V_SYNC - 1) : 11'(V_BP - 1));
    line_end   = hstate == BP && hlast;
    frame_last = line_end && vstate == BP && vlast;
    hstate_n   = i_sclr ? ACT : hlast ? (hstate == BP ? ACT : state_t'(hstate + 2'd1)) : hstate;
    hcnt_n     = i_sclr || hlast ? '0 : hcnt + 11'd1;
    hpix_n     = i_sclr || line_end ? '0 : hstate == ACT ? hpix + 10'd1 : hpix;
    vstate_n   = i_sclr ? ACT : line_end && vlast ? (vstate == BP ? ACT : state_t'(vstate + 2'd1)) : vstate;
    vcnt_n     = i_sclr ? '0 : line_end ? (vlast ? '0 : vcnt + 11'd1) : vcnt;
    vpix_n     = i_sclr || frame_last ? '0 : line_end && vstate == ACT ? vpix + 9'd1 : vpix;
    hidx_n     = i_sclr || hstate != ACT ? '0 : hpix;
    vidx_n     = i_sclr || vstate != ACT ? '0 : vpix;
    haddr_n    = !i_sclr && hstate == ACT;
    vaddr_n    = !i_sclr && vstate == ACT;
    hsync_n    = !i_sclr && hstate == SYNC ? SYNC_POL : ~SYNC_POL;
    vsync_n    = !i_sclr && vstate == SYNC ? SYNC_POL : ~SYNC_POL;
    frame_n    = !i_sclr && i_px_clk && frame_last;
  end
  // frame_en reloads every clk so the pulse is one clk wide even with slow ticks.
  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      hstate          <= ACT;
      vstate          <= ACT;
      hcnt            <= '0;
      vcnt            <= '0;
      hpix            <= '0;
      vpix            <= '0;
      vga.o_hidx      <= '0;
      vga.o_vidx      <= '0;
      vga.o_haddr_enb <= 1'b0;
      vga.o_vaddr_enb <= 1'b0;
      vga.o_hsync     <= ~SYNC_POL;
      vga.o_vsync     <= ~SYNC_POL;
      vga.o_frame_en  <= 1'b0;
    end else begin
      vga.o_frame_en <= frame_n;
      if (i_sclr || i_px_clk) begin
        hstate          <= hstate_n;
        vstate          <= vstate_n;
        hcnt            <= hcnt_n;
        vcnt            <= vcnt_n;
        hpix            <= hpix_n;
        vpix            <= vpix_n;
        vga.o_hidx      <= hidx_n;
        vga.o_vidx      <= vidx_n;
        vga.o_haddr_enb <= haddr_n;
        vga.o_vaddr_enb <= vaddr_n;
        vga.o_hsync     <= hsync_n;
        vga.o_vsync     <= vsync_n;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_640_480.sv
// tb_vga_timing_640_480: directed vector checks of the default and a tiny-raster timing generator
module tb_vga_timing_640_480;
  logic clk = 1'b0;
  logic arst, sclr, px, arst2, sclr2, px2;
  int   pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  vga_timing_640_480_if m_if();
  vga_timing_640_480_if s_if();
  vga_timing_640_480 dut (.clk(clk), .i_arst(arst), .i_sclr(sclr), .i_px_clk(px), .vga(m_if));
  vga_timing_640_480 #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                       .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1))
    dut_s (.clk(clk), .i_arst(arst2), .i_sclr(sclr2), .i_px_clk(px2), .vga(s_if));
  typedef struct { int t; int hen; int hidx; int hs; int ven; int vidx; int vs; int fe; } vec_t;
  vec_t mv[11];
  vec_t sv[17];
  task automatic chk(input string nm, input int t, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s @%0d: got %0d expected %0d", nm, t, act, exp);
  endtask
  task automatic chk_m(input vec_t v);
    chk("m_haddr_enb", v.t, int'(m_if.o_haddr_enb), v.hen);
    chk("m_hidx", v.t, int'(m_if.o_hidx), v.hidx);
    chk("m_hsync", v.t, int'(m_if.o_hsync), v.hs);
    chk("m_vaddr_enb", v.t, int'(m_if.o_vaddr_enb), v.ven);
    chk("m_vidx", v.t, int'(m_if.o_vidx), v.vidx);
    chk("m_vsync", v.t, int'(m_if.o_vsync), v.vs);
    chk("m_frame_en", v.t, int'(m_if.o_frame_en), v.fe);
  endtask
  task automatic chk_s(input vec_t v);
    chk("s_haddr_enb", v.t, int'(s_if.o_haddr_enb), v.hen);
    chk("s_hidx", v.t, int'(s_if.o_hidx), v.hidx);
    chk("s_hsync", v.t, int'(s_if.o_hsync), v.hs);
    chk("s_vaddr_enb", v.t, int'(s_if.o_vaddr_enb), v.ven);
    chk("s_vidx", v.t, int'(s_if.o_vidx), v.vidx);
    chk("s_vsync", v.t, int'(s_if.o_vsync), v.vs);
    chk("s_frame_en", v.t, int'(s_if.o_frame_en), v.fe);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k, hen_cnt, hs_cnt, idx_err, chg, rise0, rise1, nrise, fe_cnt, vs_cnt, ven_cnt, fe_at0, fe_at1;
    logic prev_hen;
    logic [9:0] prev_hidx;
    mv = '{'{1, 1, 0, 1, 1, 0, 1, 0}, '{2, 1, 1, 1, 1, 0, 1, 0}, '{640, 1, 639, 1, 1, 0, 1, 0},
           '{641, 0, 0, 1, 1, 0, 1, 0}, '{656, 0, 0, 1, 1, 0, 1, 0}, '{657, 0, 0, 0, 1, 0, 1, 0},
           '{752, 0, 0, 0, 1, 0, 1, 0}, '{753, 0, 0, 1, 1, 0, 1, 0}, '{800, 0, 0, 1, 1, 0, 1, 0},
           '{801, 1, 0, 1, 1, 1, 1, 0}, '{802, 1, 1, 1, 1, 1, 1, 0}};
    sv = '{'{1, 1, 0, 0, 1, 0, 0, 0}, '{8, 1, 7, 0, 1, 0, 0, 0}, '{9, 0, 0, 0, 1, 0, 0, 0},
           '{10, 0, 0, 0, 1, 0, 0, 0}, '{11, 0, 0, 1, 1, 0, 0, 0}, '{12, 0, 0, 1, 1, 0, 0, 0},
           '{13, 0, 0, 0, 1, 0, 0, 0}, '{15, 1, 0, 0, 1, 1, 0, 0}, '{56, 0, 0, 0, 1, 3, 0, 0},
           '{57, 1, 0, 0, 0, 0, 0, 0}, '{71, 1, 0, 0, 0, 0, 1, 0}, '{84, 0, 0, 0, 0, 0, 1, 0},
           '{85, 1, 0, 0, 0, 0, 0, 0}, '{97, 0, 0, 0, 0, 0, 0, 0}, '{98, 0, 0, 0, 0, 0, 0, 1},
           '{99, 1, 0, 0, 1, 0, 0, 0}, '{196, 0, 0, 0, 0, 0, 0, 1}};
    arst = 1'b1; sclr = 1'b0; px = 1'b0;
    arst2 = 1'b1; sclr2 = 1'b0; px2 = 1'b0;
    repeat (2) tick();
    chk_m('{0, 0, 0, 1, 0, 0, 1, 0});
    chk_s('{0, 0, 0, 0, 0, 0, 0, 0});
    // Default raster, one pixel per clk: first line and start of the second
    arst = 1'b0; px = 1'b1;
    k = 0; hen_cnt = 0; hs_cnt = 0; idx_err = 0;
    for (int t = 1; t <= 802; t++) begin
      tick();
      if (t <= 800) begin
        hen_cnt += int'(m_if.o_haddr_enb);
        hs_cnt  += int'(!m_if.o_hsync);
        if (m_if.o_haddr_enb && int'(m_if.o_hidx) != t - 1) idx_err++;
        if (!m_if.o_haddr_enb && m_if.o_hidx != 10'd0) idx_err++;
      end
      if (k < 11 && mv[k].t == t) begin
        chk_m(mv[k]);
        k++;
      end
    end
    chk("m_hen_count", 800, hen_cnt, 640);
    chk("m_hsync_low_count", 800, hs_cnt, 96);
    chk("m_hidx_sequence", 800, idx_err, 0);
    // Synchronous clear with a tick in the same cycle
    tick();
    sclr = 1'b1;
    tick();
    chk_m('{1000, 0, 0, 1, 0, 0, 1, 0});
    sclr = 1'b0;
    tick();
    chk_m('{1001, 1, 0, 1, 1, 0, 1, 0});
    // Asynchronous reset between edges at column 300
    repeat (300) tick();
    chk("m_hidx_pre_arst", 2000, int'(m_if.o_hidx), 300);
    #2 arst = 1'b1;
    #1 chk_m('{2000, 0, 0, 1, 0, 0, 1, 0});
    tick();
    arst = 1'b0;
    tick();
    chk_m('{2001, 1, 0, 1, 1, 0, 1, 0});
    // Pixel tick every 4th clk
    arst = 1'b1; px = 1'b0;
    tick();
    arst = 1'b0;
    chg = 0; nrise = 0; rise0 = -1; rise1 = -1; prev_hen = 1'b0;
    for (int c = 0; c < 7000; c++) begin
      px = (c % 4 == 0);
      prev_hidx = m_if.o_hidx;
      tick();
      if (!px && m_if.o_hidx != prev_hidx) chg++;
      if (m_if.o_haddr_enb && !prev_hen) begin
        if (nrise == 0) rise0 = c;
        else if (nrise == 1) rise1 = c;
        nrise++;
      end
      prev_hen = m_if.o_haddr_enb;
    end
    px = 1'b1;
    chk("m_change_off_tick", 3000, chg, 0);
    chk("m_first_line_clk", 3000, rise0, 0);
    chk("m_line_period_clk", 3000, rise1 - rise0, 3200);
    // Tiny raster, polarity high, one pixel per clk over three frames
    arst2 = 1'b0; px2 = 1'b1;
    k = 0; fe_cnt = 0; vs_cnt = 0; ven_cnt = 0; hs_cnt = 0; idx_err = 0;
    for (int t = 1; t <= 294; t++) begin
      tick();
      fe_cnt  += int'(s_if.o_frame_en);
      vs_cnt  += int'(s_if.o_vsync);
      ven_cnt += int'(s_if.o_vaddr_enb);
      hs_cnt  += int'(s_if.o_hsync);
      if (int'(s_if.o_hsync) != int'((t - 1) % 14 == 10 || (t - 1) % 14 == 11)) idx_err++;
      if (int'(s_if.o_frame_en) != int'(t % 98 == 0)) idx_err++;
      if (k < 17 && sv[k].t == t) begin
        chk_s(sv[k]);
        k++;
      end
    end
    chk("s_frame_en_count", 294, fe_cnt, 3);
    chk("s_vsync_high_count", 294, vs_cnt, 42);
    chk("s_vaddr_enb_count", 294, ven_cnt, 168);
    chk("s_hsync_high_count", 294, hs_cnt, 42);
    chk("s_hsync_frame_positions", 294, idx_err, 0);
    // Tiny raster with a tick every 4th clk: frame_en is one clk wide
    arst2 = 1'b1; px2 = 1'b0;
    tick();
    arst2 = 1'b0;
    fe_cnt = 0; fe_at0 = -1; fe_at1 = -1;
    for (int c = 0; c < 800; c++) begin
      px2 = (c % 4 == 0);
      tick();
      if (s_if.o_frame_en) begin
        if (fe_cnt == 0) fe_at0 = c;
        else if (fe_cnt == 1) fe_at1 = c;
        fe_cnt++;
      end
    end
    chk("s_frame_en_clks", 800, fe_cnt, 2);
    chk("s_frame_en_first", 800, fe_at0, 388);
    chk("s_frame_period_clk", 800, fe_at1 - fe_at0, 392);
    // Tiny raster: asynchronous reset mid-frame while hsync is asserted
    arst2 = 1'b1; px2 = 1'b0;
    tick();
    arst2 = 1'b0; px2 = 1'b1;
    repeat (25) tick();
    chk_s('{4000, 0, 0, 1, 1, 1, 0, 0});
    #2 arst2 = 1'b1;
    #1 chk_s('{4001, 0, 0, 0, 0, 0, 0, 0});
    tick();
    arst2 = 1'b0;
    tick();
    chk_s('{4002, 1, 0, 0, 1, 0, 0, 0});
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
